// File: rtl/mem_port_arbiter_if.sv
// Bundles the fetch requester, data requester, memory port and status signals
// that meet at mem_port_arbiter.
interface mem_port_arbiter_if;
    logic        if_req;
    logic [31:0] if_addr;
    logic        if_ack;
    logic [31:0] if_rdata;

    logic        dm_req;
    logic        dm_we;
    logic [31:0] dm_addr;
    logic [31:0] dm_wdata;
    logic        dm_ack;
    logic [31:0] dm_rdata;

    logic [31:0] mem_addr;
    logic        mem_read_enable;
    logic        mem_write_enable;
    logic [31:0] mem_write_data;
    logic [31:0] mem_read_data;

    logic        busy;

    modport slave (
        input  if_req, if_addr, dm_req, dm_we, dm_addr, dm_wdata, mem_read_data,
        output if_ack, if_rdata, dm_ack, dm_rdata,
               mem_addr, mem_read_enable, mem_write_enable, mem_write_data, busy
    );

    modport master (
        output if_req, if_addr, dm_req, dm_we, dm_addr, dm_wdata, mem_read_data,
        input  if_ack, if_rdata, dm_ack, dm_rdata,
               mem_addr, mem_read_enable, mem_write_enable, mem_write_data, busy
    );
endinterface

// File: rtl/mem_port_arbiter.sv
// Shares one single-port memory between instruction fetch and data access.
// Define MEM_ARB_ROUND_ROBIN_EN to alternate grants on conflict instead of data priority.
module mem_port_arbiter #(
    parameter int unsigned WAIT_STATES = 1
) (
    input  logic               clock,
    input  logic               reset,
    mem_port_arbiter_if.slave  bus
);
    typedef enum logic {IDLE = 1'b0, ACCESS = 1'b1} state_t;
    typedef enum logic {FETCH = 1'b0, DATA = 1'b1} owner_t;

    state_t     state, state_nxt;
    owner_t     owner, win;
    logic [3:0] cnt;
    logic       if_elig, dm_elig, grant;
`ifdef MEM_ARB_ROUND_ROBIN_EN
    owner_t     last;
`endif

    // A requester is ignored during its own ack cycle so a held req is not re-granted.
    always_comb begin
        if_elig   = bus.if_req && !bus.if_ack;
        dm_elig   = bus.dm_req && !bus.dm_ack;
        grant     = 1'b0;
        win       = FETCH;
        state_nxt = state;
        case (state)
            IDLE: begin
                if (if_elig || dm_elig) begin
                    grant     = 1'b1;
                    state_nxt = ACCESS;
                    if (if_elig && dm_elig) begin
`ifdef MEM_ARB_ROUND_ROBIN_EN
                        win = (last == FETCH) ? DATA : FETCH;
`else
                        win = DATA;
`endif
                    end else begin
                        win = dm_elig ? DATA : FETCH;
                    end
                end
            end
            ACCESS: if (cnt == 4'd0) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) state <= IDLE;
        else       state <= state_nxt;
    end

    assign bus.busy = (state == ACCESS);

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            cnt                  <= 4'd0;
            owner                <= FETCH;
            bus.if_ack           <= 1'b0;
            bus.dm_ack           <= 1'b0;
            bus.if_rdata         <= 32'd0;
            bus.dm_rdata         <= 32'd0;
            bus.mem_addr         <= 32'd0;
            bus.mem_read_enable  <= 1'b0;
            bus.mem_write_enable <= 1'b0;
            bus.mem_write_data   <= 32'd0;
`ifdef MEM_ARB_ROUND_ROBIN_EN
            last                 <= FETCH;
`endif
        end else begin
            bus.if_ack <= 1'b0;
            bus.dm_ack <= 1'b0;
            if (grant) begin
                owner                <= win;
                cnt                  <= 4'(WAIT_STATES);
                bus.mem_addr         <= (win == DATA) ? bus.dm_addr : bus.if_addr;
                bus.mem_read_enable  <= (win == FETCH) || !bus.dm_we;
                bus.mem_write_enable <= (win == DATA) && bus.dm_we;
                bus.mem_write_data   <= (win == DATA) ? bus.dm_wdata : 32'd0;
`ifdef MEM_ARB_ROUND_ROBIN_EN
                last                 <= win;
`endif
            end else if (state == ACCESS) begin
                if (cnt != 4'd0) begin
                    cnt <= cnt - 4'd1;
                end else begin
                    bus.mem_read_enable  <= 1'b0;
                    bus.mem_write_enable <= 1'b0;
                    if (owner == FETCH) begin
                        bus.if_rdata <= bus.mem_read_data;
                        bus.if_ack   <= 1'b1;
                    end else begin
                        if (!bus.mem_write_enable) bus.dm_rdata <= bus.mem_read_data;
                        bus.dm_ack <= 1'b1;
                    end
                end
            end
        end
    end
endmodule

// File: tb/tb_mem_port_arbiter.sv
// Scoreboard bench for mem_port_arbiter: requester tasks queue expected transactions,
// a negedge monitor checks grants, memory-port drive, ack timing and read data.
module tb_mem_port_arbiter;
    localparam int WS = 1;

    logic clock = 1'b0;
    logic reset = 1'b1;
    always #5 clock = ~clock;

    mem_port_arbiter_if b1();
    mem_port_arbiter_if b0();

    mem_port_arbiter #(.WAIT_STATES(WS)) dut  (.clock(clock), .reset(reset), .bus(b1));
    mem_port_arbiter #(.WAIT_STATES(0))  dut0 (.clock(clock), .reset(reset), .bus(b0));

    int errors = 0;
    int checks = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] pat(input logic [31:0] a);
        return (a * 32'h9E37_79B9) ^ 32'hA5A5_0000;
    endfunction

    // Memory environment seen by the DUT, and an independent reference image
    logic [31:0] mem     [int unsigned];
    logic [31:0] ref_mem [int unsigned];

    function automatic logic [31:0] ref_rd(input logic [31:0] a);
        return ref_mem.exists(a) ? ref_mem[a] : pat(a);
    endfunction

    always @(negedge clock) begin
        if (b1.mem_write_enable) mem[b1.mem_addr] = b1.mem_write_data;
        b1.mem_read_data = mem.exists(b1.mem_addr) ? mem[b1.mem_addr] : pat(b1.mem_addr);
    end
    assign b0.mem_read_data = ~b0.mem_addr;

    typedef struct {
        logic [31:0] addr;
        logic        we;
        logic [31:0] wdata;
        logic [31:0] rdata;
    } txn_t;
    txn_t fq[$];
    txn_t dq[$];

    task automatic do_fetch(input logic [31:0] a, output int edges);
        txn_t t;
        t.addr = a; t.we = 1'b0; t.wdata = 32'd0; t.rdata = ref_rd(a);
        fq.push_back(t);
        b1.if_req  = 1'b1;
        b1.if_addr = a;
        edges = 0;
        forever begin
            @(posedge clock); #1;
            edges++;
            if (b1.if_ack) break;
            if (edges > 60) begin chk("if_ack_timeout", 32'd0, 32'd1); break; end
        end
        b1.if_req = 1'b0;
    endtask

    // scramble: after the first edge (grant from idle) corrupt inputs and drop req
    task automatic do_data(input logic [31:0] a, input logic we, input logic [31:0] wd,
                           input bit scramble, output int edges);
        txn_t t;
        if (we) ref_mem[a] = wd;
        t.addr = a; t.we = we; t.wdata = wd; t.rdata = we ? 32'd0 : ref_rd(a);
        dq.push_back(t);
        b1.dm_req   = 1'b1;
        b1.dm_we    = we;
        b1.dm_addr  = a;
        b1.dm_wdata = wd;
        edges = 0;
        forever begin
            @(posedge clock); #1;
            edges++;
            if (b1.dm_ack) break;
            if (scramble && edges == 1) begin
                b1.dm_addr  = $urandom;
                b1.dm_wdata = $urandom;
                b1.dm_req   = 1'b0;
            end
            if (edges > 60) begin chk("dm_ack_timeout", 32'd0, 32'd1); break; end
        end
        b1.dm_req = 1'b0;
    endtask

    // Monitor with a rule-level arbitration model
    bit          mon_en = 0;
    logic        pb = 0, pe_if = 0, pe_dm = 0;
    bit          last_d = 0, cur_d = 0, mo;
    logic        cur_re = 0, cur_we = 0;
    int          since = 0;
    logic [31:0] dm_hold = 32'd0;
    txn_t        mt;

    always @(negedge clock) if (mon_en) begin
        chk("excl_enables", 32'(b1.mem_read_enable && b1.mem_write_enable), 32'd0);
        if (b1.busy && !pb) begin
            if (!pe_if && !pe_dm) chk("grant_without_req", 32'd0, 32'd1);
            if (pe_if && pe_dm) begin
`ifdef MEM_ARB_ROUND_ROBIN_EN
                mo = !last_d;
`else
                mo = 1'b1;
`endif
            end else mo = pe_dm;
            last_d = mo; cur_d = mo; since = 0;
            if ((mo ? dq.size() : fq.size()) == 0) chk("grant_queue_empty", 32'd0, 32'd1);
            else begin
                mt = mo ? dq[0] : fq[0];
                cur_re = !mo || !mt.we;
                cur_we = mo && mt.we;
                chk("grant_addr", b1.mem_addr, mt.addr);
                chk("grant_re", 32'(b1.mem_read_enable), 32'(cur_re));
                chk("grant_we", 32'(b1.mem_write_enable), 32'(cur_we));
                if (cur_we) chk("grant_wdata", b1.mem_write_data, mt.wdata);
            end
        end else if (b1.busy) begin
            since++;
            chk("hold_re", 32'(b1.mem_read_enable), 32'(cur_re));
            chk("hold_we", 32'(b1.mem_write_enable), 32'(cur_we));
        end else begin
            chk("idle_enables", {30'd0, b1.mem_read_enable, b1.mem_write_enable}, 32'd0);
        end
        if (b1.if_ack || b1.dm_ack) begin
            chk("ack_both", 32'(b1.if_ack && b1.dm_ack), 32'd0);
            chk("ack_owner", 32'(b1.dm_ack), 32'(cur_d));
            chk("ack_after_busy", 32'(pb), 32'd1);
            chk("ack_latency", 32'(since), 32'(WS));
        end
        if (b1.if_ack) begin
            if (fq.size() == 0) chk("if_ack_unexpected", 32'd1, 32'd0);
            else begin mt = fq.pop_front(); chk("if_rdata", b1.if_rdata, mt.rdata); end
        end
        if (b1.dm_ack) begin
            if (dq.size() == 0) chk("dm_ack_unexpected", 32'd1, 32'd0);
            else begin
                mt = dq.pop_front();
                if (mt.we) chk("dm_rdata_hold", b1.dm_rdata, dm_hold);
                else begin chk("dm_rdata", b1.dm_rdata, mt.rdata); dm_hold = mt.rdata; end
            end
        end
        pe_if = b1.if_req && !b1.if_ack;
        pe_dm = b1.dm_req && !b1.dm_ack;
        pb    = b1.busy;
    end

    task automatic chk_outputs_zero(input string tag);
        chk({tag, "_if_ack"},   32'(b1.if_ack), 32'd0);
        chk({tag, "_dm_ack"},   32'(b1.dm_ack), 32'd0);
        chk({tag, "_if_rdata"}, b1.if_rdata, 32'd0);
        chk({tag, "_dm_rdata"}, b1.dm_rdata, 32'd0);
        chk({tag, "_mem_addr"}, b1.mem_addr, 32'd0);
        chk({tag, "_mem_re"},   32'(b1.mem_read_enable), 32'd0);
        chk({tag, "_mem_we"},   32'(b1.mem_write_enable), 32'd0);
        chk({tag, "_mem_wd"},   b1.mem_write_data, 32'd0);
        chk({tag, "_busy"},     32'(b1.busy), 32'd0);
    endtask

    int e, ef, ed;

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        b1.if_req = 0; b1.if_addr = 0; b1.dm_req = 0; b1.dm_we = 0; b1.dm_addr = 0; b1.dm_wdata = 0;
        b0.if_req = 0; b0.if_addr = 0; b0.dm_req = 0; b0.dm_we = 0; b0.dm_addr = 0; b0.dm_wdata = 0;
        mem[3] = 32'hDEAD_BEEF;
        ref_mem[3] = 32'hDEAD_BEEF;
        repeat (2) @(posedge clock);
        #1 chk_outputs_zero("reset");
        @(negedge clock) reset = 1'b0;
        mon_en = 1;

        // single fetch from idle
        @(posedge clock); #1;
        do_fetch(32'd3, e);
        chk("fetch_latency", 32'(e), 32'd3);
        chk("fetch_data", b1.if_rdata, 32'hDEAD_BEEF);
        repeat (2) @(posedge clock); #1;

        // store (inputs corrupted after grant) then load
        do_data(32'd7, 1'b1, 32'h1234_5678, 1'b1, e);
        chk("store_latency", 32'(e), 32'd3);
        chk("store_commit", mem[7], 32'h1234_5678);
        @(posedge clock); #1;
        do_data(32'd7, 1'b0, 32'd0, 1'b0, e);
        chk("load_data", b1.dm_rdata, 32'h1234_5678);
        repeat (2) @(posedge clock); #1;

        // simultaneous requests
        fork
            do_fetch(32'd5, ef);
            do_data(32'h101, 1'b0, 32'd0, 1'b0, ed);
        join
`ifdef MEM_ARB_ROUND_ROBIN_EN
        chk("conflict_if_edges", 32'(ef), 32'd3);
        chk("conflict_dm_edges", 32'(ed), 32'd6);
`else
        chk("conflict_dm_edges", 32'(ed), 32'd3);
        chk("conflict_if_edges", 32'(ef), 32'd6);
`endif
        repeat (2) @(posedge clock); #1;

        // sustained conflict: both held back-to-back
        fork
            for (int i = 0; i < 4; i++) do_fetch(32'(i + 8), ef);
            for (int i = 0; i < 4; i++) do_data(32'h108 + 32'(i), 1'(i), 32'hC0DE_0000 + 32'(i), 1'b0, ed);
        join
        repeat (2) @(posedge clock); #1;

        // randomized traffic
        fork
            for (int i = 0; i < 40; i++) begin
                repeat ($urandom_range(0, 3)) begin @(posedge clock); #1; end
                do_fetch(32'($urandom_range(0, 15)), ef);
            end
            for (int i = 0; i < 40; i++) begin
                repeat ($urandom_range(0, 3)) begin @(posedge clock); #1; end
                do_data(32'h100 + 32'($urandom_range(0, 15)), 1'($urandom_range(0, 1)), $urandom, 1'b0, ed);
            end
        join
        repeat (4) @(posedge clock); #1;
        chk("fq_drained", 32'(fq.size()), 32'd0);
        chk("dq_drained", 32'(dq.size()), 32'd0);

        // zero wait states, full 32-bit address
        b0.if_req = 1'b1; b0.if_addr = 32'hFFFF_F004;
        @(posedge clock); #1;
        chk("ws0_addr", b0.mem_addr, 32'hFFFF_F004);
        chk("ws0_re", 32'(b0.mem_read_enable), 32'd1);
        chk("ws0_busy", 32'(b0.busy), 32'd1);
        chk("ws0_early_ack", 32'(b0.if_ack), 32'd0);
        @(posedge clock); #1;
        chk("ws0_if_ack", 32'(b0.if_ack), 32'd1);
        chk("ws0_re_off", 32'(b0.mem_read_enable), 32'd0);
        chk("ws0_if_rdata", b0.if_rdata, 32'h0000_0FFB);
        b0.if_req = 1'b0;
        b0.dm_req = 1'b1; b0.dm_we = 1'b1; b0.dm_addr = 32'hFFFF_F004; b0.dm_wdata = 32'hCAFE_F00D;
        @(posedge clock); #1;
        chk("ws0_st_we", 32'(b0.mem_write_enable), 32'd1);
        chk("ws0_st_re", 32'(b0.mem_read_enable), 32'd0);
        chk("ws0_st_wd", b0.mem_write_data, 32'hCAFE_F00D);
        @(posedge clock); #1;
        chk("ws0_dm_ack", 32'(b0.dm_ack), 32'd1);
        chk("ws0_st_we_off", 32'(b0.mem_write_enable), 32'd0);
        chk("ws0_dm_rdata", b0.dm_rdata, 32'd0);
        b0.dm_req = 1'b0;
        repeat (2) @(posedge clock); #1;

        // reset in the middle of a load
        mon_en = 0;
        b1.dm_req = 1'b1; b1.dm_we = 1'b0; b1.dm_addr = 32'h105;
        @(posedge clock); #1;
        chk("mid_busy", 32'(b1.busy), 32'd1);
        @(posedge clock); #3;
        reset = 1'b1;
        #1 chk_outputs_zero("async_reset");
        b1.dm_req = 1'b0;
        fq.delete(); dq.delete();
        @(posedge clock);
        @(negedge clock) reset = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(posedge clock); #1;
            chk("no_stale_ack", 32'(b1.dm_ack), 32'd0);
        end
        last_d = 0; pb = 0; pe_if = 0; pe_dm = 0; dm_hold = 32'd0;
        mon_en = 1;
        do_data(32'h105, 1'b0, 32'd0, 1'b0, e);
        chk("post_reset_latency", 32'(e), 32'd3);
        repeat (2) @(posedge clock); #1;
        chk("final_dq_drained", 32'(dq.size()), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
